// File: rtl/updown_counter_unit.sv
// updown_counter_unit
// Up/down counter with a button-handling FSM. Its features:
//   - a configurable step size;
//   - a choice of saturate or modulo wrap at a programmable upper limit;
//   - press-and-hold auto-repeat on the u/d buttons.
// The count register and the limit flags live in this block.
module updown_counter_unit #(
   parameter int WIDTH         = 8,
   parameter int MAX_VAL       = 255,
   parameter int STEP          = 1,
   parameter int WRAP          = 0,
   parameter int HOLD_CYCLES   = 16,
   parameter int REPEAT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             u,
   input  logic             d,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             z,
   output logic             m,
   output logic             lim,
   output logic [2:0]       state
);

   // Repeat timer: wide enough for the longer of the two intervals.
   localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   // A STEP state and the following HOLD evaluation both consume cycles.
   // The timer therefore starts two below the interval, so the next step
   // lands exactly HOLD_CYCLES or REPEAT_CYCLES edges after the previous one.
   localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 2);
   localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYCLES - 2);

   // Arithmetic is carried one bit wider than the count so sums never overflow.
   localparam int EW = WIDTH + 1;
   localparam logic [EW-1:0]    MAX_EXT  = EW'(MAX_VAL);
   localparam logic [EW-1:0]    STEP_EXT = EW'(STEP);
   localparam logic [EW-1:0]    MOD_EXT  = EW'(MAX_VAL + 1);
   localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STEP_UP = 3'd1,
      ST_HOLD_UP = 3'd2,
      ST_STEP_DN = 3'd3,
      ST_HOLD_DN = 3'd4,
      ST_LOCK    = 3'd5
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [TW-1:0]    timer_r, timer_nxt_s;
   logic             first_r, first_nxt_s;
   logic [WIDTH-1:0] count_r, count_nxt_s;
   logic             lim_r, lim_nxt_s;

   logic [EW-1:0]    cnt_ext_s;
   logic [EW-1:0]    up_val_s;
   logic [EW-1:0]    dn_val_s;
   logic             up_refuse_s;
   logic             dn_refuse_s;

   // Next-state logic: button decoding, hold timing and lockout.
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      first_nxt_s = first_r;
      case (state_r)
         ST_IDLE: begin
            if (u && !d) begin
               state_nxt_s = ST_STEP_UP;
               first_nxt_s = 1'b1;
            end else if (!u && d) begin
               state_nxt_s = ST_STEP_DN;
               first_nxt_s = 1'b1;
            end else if (u && d) begin
               state_nxt_s = ST_LOCK;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_STEP_UP: begin
            state_nxt_s = ST_HOLD_UP;
            timer_nxt_s = first_r ? HOLD_LOAD : REPEAT_LOAD;
         end
         ST_STEP_DN: begin
            state_nxt_s = ST_HOLD_DN;
            timer_nxt_s = first_r ? HOLD_LOAD : REPEAT_LOAD;
         end
         ST_HOLD_UP: begin
            if (!u) begin
               state_nxt_s = ST_IDLE;
            end else if (d) begin
               state_nxt_s = ST_LOCK;
            end else if (timer_r == {TW{1'b0}}) begin
               state_nxt_s = ST_STEP_UP;
               first_nxt_s = 1'b0;
            end else begin
               timer_nxt_s = timer_r - TW'(1);
            end
         end
         ST_HOLD_DN: begin
            if (!d) begin
               state_nxt_s = ST_IDLE;
            end else if (u) begin
               state_nxt_s = ST_LOCK;
            end else if (timer_r == {TW{1'b0}}) begin
               state_nxt_s = ST_STEP_DN;
               first_nxt_s = 1'b0;
            end else begin
               timer_nxt_s = timer_r - TW'(1);
            end
         end
         ST_LOCK: begin
            if (!u && !d) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_LOCK;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            timer_nxt_s = {TW{1'b0}};
            first_nxt_s = 1'b0;
         end
      endcase
   end

   // FSM state, repeat timer and first-step flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         timer_r <= {TW{1'b0}};
         first_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         timer_r <= timer_nxt_s;
         first_r <= first_nxt_s;
      end
   end

   // Candidate up/down results and refusal detection for the current count.
   always_comb begin
      cnt_ext_s   = {1'b0, count_r};
      up_val_s    = cnt_ext_s + STEP_EXT;
      dn_val_s    = cnt_ext_s - STEP_EXT;
      up_refuse_s = 1'b0;
      dn_refuse_s = 1'b0;
      if (WRAP != 0) begin
         if (up_val_s > MAX_EXT) begin
            up_val_s = up_val_s - MOD_EXT;
         end else begin
            up_val_s = up_val_s;
         end
         if (cnt_ext_s < STEP_EXT) begin
            dn_val_s = cnt_ext_s + MOD_EXT - STEP_EXT;
         end else begin
            dn_val_s = dn_val_s;
         end
      end else begin
         up_refuse_s = (cnt_ext_s == MAX_EXT);
         dn_refuse_s = (cnt_ext_s == {EW{1'b0}});
         if (cnt_ext_s > MAX_EXT - STEP_EXT) begin
            up_val_s = MAX_EXT;
         end else begin
            up_val_s = up_val_s;
         end
         if (cnt_ext_s < STEP_EXT) begin
            dn_val_s = {EW{1'b0}};
         end else begin
            dn_val_s = dn_val_s;
         end
      end
   end

   // Count update: clear wins, otherwise apply the step of a STEP state.
   always_comb begin
      count_nxt_s = count_r;
      lim_nxt_s   = 1'b0;
      if (clr) begin
         count_nxt_s = {WIDTH{1'b0}};
         lim_nxt_s   = 1'b0;
      end else if (state_r == ST_STEP_UP) begin
         count_nxt_s = up_val_s[WIDTH-1:0];
         lim_nxt_s   = up_refuse_s;
      end else if (state_r == ST_STEP_DN) begin
         count_nxt_s = dn_val_s[WIDTH-1:0];
         lim_nxt_s   = dn_refuse_s;
      end else begin
         count_nxt_s = count_r;
         lim_nxt_s   = 1'b0;
      end
   end

   // Count register and the one-cycle refusal pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= {WIDTH{1'b0}};
         lim_r   <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         lim_r   <= lim_nxt_s;
      end
   end

   assign count = count_r;
   assign lim   = lim_r;
   assign state = state_r;
   assign z     = (count_r == {WIDTH{1'b0}});
   assign m     = (count_r == MAX_W);

endmodule

// File: tb/tb_updown_counter_unit.sv
// Bench for updown_counter_unit.
// Three instances share one stimulus stream:
//   - default parameters;
//   - saturating with MAX_VAL=10, STEP=3;
//   - wrapping with MAX_VAL=200, STEP=3.
// A press-age model predicts every count/flag each cycle. Directed literal
// checks pin the model at the interesting points.
module tb_updown_counter_unit;

   localparam int H = 16;
   localparam int R = 4;
   localparam int MAXV [3] = '{255, 10, 200};
   localparam int STPV [3] = '{1, 3, 3};
   localparam int WRPV [3] = '{0, 0, 1};

   logic clk;
   logic reset;
   logic u;
   logic d;
   logic clr;

   logic [7:0] count0, count1, count2;
   logic       z0, z1, z2, m0, m1, m2, lim0, lim1, lim2;
   logic [2:0] state0, state1, state2;

   logic [7:0] cnt_a [3];
   logic       z_a   [3];
   logic       m_a   [3];
   logic       lim_a [3];

   int n_cmp;
   int n_err;

   // Model state
   bit m_act, m_up, m_lock;
   int m_age;
   int m_cnt [3];
   bit m_lim [3];

   updown_counter_unit u_dut0 (
      .clk(clk), .reset(reset), .u(u), .d(d), .clr(clr),
      .count(count0), .z(z0), .m(m0), .lim(lim0), .state(state0)
   );

   updown_counter_unit #(.MAX_VAL(10), .STEP(3), .WRAP(0)) u_dut1 (
      .clk(clk), .reset(reset), .u(u), .d(d), .clr(clr),
      .count(count1), .z(z1), .m(m1), .lim(lim1), .state(state1)
   );

   updown_counter_unit #(.MAX_VAL(200), .STEP(3), .WRAP(1)) u_dut2 (
      .clk(clk), .reset(reset), .u(u), .d(d), .clr(clr),
      .count(count2), .z(z2), .m(m2), .lim(lim2), .state(state2)
   );

   assign cnt_a[0] = count0;
   assign cnt_a[1] = count1;
   assign cnt_a[2] = count2;
   assign z_a[0]   = z0;
   assign z_a[1]   = z1;
   assign z_a[2]   = z2;
   assign m_a[0]   = m0;
   assign m_a[1]   = m1;
   assign m_a[2]   = m2;
   assign lim_a[0] = lim0;
   assign lim_a[1] = lim1;
   assign lim_a[2] = lim2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // A press sampled at age 0 steps at age 1, at 1+H, then every R.
   function automatic bit step_due(input int a);
      return (a == 1) || ((a >= 1 + H) && (((a - 1 - H) % R) == 0));
   endfunction

   // Behavioural model: press age drives step timing; plain integer arithmetic sets the count.
   always @(posedge clk or negedge reset) begin : model
      bit act_n, up_n, lock_n, do_up, do_dn, l_n;
      int age_n, c_n;
      if (!reset) begin
         m_act  <= 1'b0;
         m_up   <= 1'b0;
         m_lock <= 1'b0;
         m_age  <= 0;
         for (int i = 0; i < 3; i++) begin
            m_cnt[i] <= 0;
            m_lim[i] <= 1'b0;
         end
      end else begin
         act_n  = m_act;
         up_n   = m_up;
         lock_n = m_lock;
         age_n  = m_age;
         do_up  = 1'b0;
         do_dn  = 1'b0;
         if (lock_n) begin
            if (!u && !d) lock_n = 1'b0;
         end else if (!act_n) begin
            if (u && d) begin
               lock_n = 1'b1;
            end else if (u || d) begin
               act_n = 1'b1;
               up_n  = u;
               age_n = 0;
            end
         end else begin
            age_n = age_n + 1;
            if (step_due(age_n)) begin
               do_up = up_n;
               do_dn = !up_n;
            end else if (!(up_n ? u : d)) begin
               act_n = 1'b0;
            end else if (u && d) begin
               act_n  = 1'b0;
               lock_n = 1'b1;
            end
         end
         m_act  <= act_n;
         m_up   <= up_n;
         m_lock <= lock_n;
         m_age  <= age_n;
         for (int i = 0; i < 3; i++) begin
            c_n = m_cnt[i];
            l_n = 1'b0;
            if (clr) begin
               c_n = 0;
            end else if (do_up) begin
               if (WRPV[i] != 0) c_n = (c_n + STPV[i]) % (MAXV[i] + 1);
               else if (c_n == MAXV[i]) l_n = 1'b1;
               else c_n = (c_n + STPV[i] > MAXV[i]) ? MAXV[i] : c_n + STPV[i];
            end else if (do_dn) begin
               if (WRPV[i] != 0) c_n = (c_n - STPV[i] + MAXV[i] + 1) % (MAXV[i] + 1);
               else if (c_n == 0) l_n = 1'b1;
               else c_n = (c_n < STPV[i]) ? 0 : c_n - STPV[i];
            end
            m_cnt[i] <= c_n;
            m_lim[i] <= l_n;
         end
      end
   end

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("model_count%0d", i), 32'(cnt_a[i]), 32'(m_cnt[i]));
            check($sformatf("model_z%0d", i), 32'(z_a[i]), 32'(m_cnt[i] == 0));
            check($sformatf("model_m%0d", i), 32'(m_a[i]), 32'(m_cnt[i] == MAXV[i]));
            check($sformatf("model_lim%0d", i), 32'(lim_a[i]), 32'(m_lim[i]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input bit pu, input bit pd, input int nh, input int nl);
      u = pu;
      d = pd;
      repeat (nh) cyc();
      u = 1'b0;
      d = 1'b0;
      repeat (nl) cyc();
   endtask

   initial begin
      int exp_up [4];
      exp_up = '{3, 6, 9, 10};
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      u     = 1'b0;
      d     = 1'b0;
      clr   = 1'b0;
      #2;
      check("rst_count", 32'(count0), 32'd0);
      check("rst_z", 32'(z0), 32'd1);
      check("rst_m", 32'(m0), 32'd0);
      check("rst_lim", 32'(lim0), 32'd0);
      check("rst_state", 32'(state0), 32'd0);
      #10;
      reset = 1'b1;
      cyc();

      // Single press up then down.
      u = 1'b1;
      cyc();
      check("press_edge_k", 32'(count0), 32'd0);
      check("press_state_step", 32'(state0), 32'd1);
      cyc();
      check("press_edge_k1", 32'(count0), 32'd1);
      cyc();
      u = 1'b0;
      repeat (4) cyc();
      check("single_up0", 32'(count0), 32'd1);
      check("single_up1", 32'(count1), 32'd3);
      check("single_up2", 32'(count2), 32'd3);
      press(1'b0, 1'b1, 3, 4);
      check("single_dn0", 32'(count0), 32'd0);
      check("single_dn_z0", 32'(z0), 32'd1);

      // Auto-repeat: 40 sampled-high edges.
      u = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (i == 16) check("repeat_before_2nd", 32'(count0), 32'd1);
         if (i == 17) check("repeat_2nd", 32'(count0), 32'd2);
      end
      u = 1'b0;
      repeat (4) cyc();
      check("repeat_final0", 32'(count0), 32'd7);
      check("repeat_final1", 32'(count1), 32'd10);
      check("repeat_final2", 32'(count2), 32'd21);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      check("clr_idle0", 32'(count0), 32'd0);
      check("clr_idle2", 32'(count2), 32'd0);

      // Saturation on instance 1.
      for (int p = 0; p < 4; p++) begin
         press(1'b1, 1'b0, 3, 3);
         check($sformatf("sat_up_%0d", p), 32'(count1), 32'(exp_up[p]));
      end
      check("sat_m", 32'(m1), 32'd1);
      u = 1'b1;
      cyc();
      cyc();
      check("sat_refuse_lim", 32'(lim1), 32'd1);
      check("sat_refuse_cnt", 32'(count1), 32'd10);
      cyc();
      check("sat_lim_one_cycle", 32'(lim1), 32'd0);
      u = 1'b0;
      repeat (3) cyc();
      repeat (4) press(1'b0, 1'b1, 3, 3);
      check("sat_dn_zero", 32'(count1), 32'd0);
      check("sat_dn_z", 32'(z1), 32'd1);
      d = 1'b1;
      cyc();
      cyc();
      check("sat_dn_refuse_lim", 32'(lim1), 32'd1);
      check("sat_dn_refuse_cnt", 32'(count1), 32'd0);
      cyc();
      check("sat_dn_lim_off", 32'(lim1), 32'd0);
      d = 1'b0;
      repeat (3) cyc();

      // Wrap on instance 2.
      press(1'b0, 1'b1, 3, 3);
      check("wrap_dn", 32'(count2), 32'd198);
      press(1'b1, 1'b0, 3, 3);
      check("wrap_up", 32'(count2), 32'd0);
      check("wrap_up_z", 32'(z2), 32'd1);

      // Lockout.
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      u = 1'b1;
      repeat (5) cyc();
      d = 1'b1;
      repeat (5) cyc();
      check("lock_state", 32'(state0), 32'd5);
      check("lock_count", 32'(count0), 32'd1);
      u = 1'b0;
      repeat (5) cyc();
      check("lock_one_released", 32'(state0), 32'd5);
      d = 1'b0;
      cyc();
      check("lock_exit", 32'(state0), 32'd0);
      u = 1'b1;
      d = 1'b1;
      repeat (3) cyc();
      check("both_idle_lock", 32'(state0), 32'd5);
      check("both_idle_nostep", 32'(count0), 32'd1);
      u = 1'b0;
      d = 1'b0;
      repeat (2) cyc();

      // Clear on the STEP_UP edge.
      repeat (3) press(1'b1, 1'b0, 3, 3);
      check("pre_clr_count", 32'(count0), 32'd4);
      u = 1'b1;
      cyc();
      check("clr_step_state", 32'(state0), 32'd1);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      check("clr_step_count", 32'(count0), 32'd0);
      check("clr_step_lim", 32'(lim0), 32'd0);
      u = 1'b0;
      repeat (4) cyc();
      check("clr_step_dropped", 32'(count0), 32'd0);

      // Asynchronous reset in the middle of a hold.
      repeat (4) press(1'b1, 1'b0, 3, 3);
      u = 1'b1;
      repeat (10) cyc();
      check("hold_count5", 32'(count0), 32'd5);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_rst_count", 32'(count0), 32'd0);
      check("async_rst_z", 32'(z0), 32'd1);
      check("async_rst_m", 32'(m0), 32'd0);
      check("async_rst_lim", 32'(lim0), 32'd0);
      check("async_rst_state", 32'(state0), 32'd0);
      u = 1'b0;
      #2;
      reset = 1'b1;
      repeat (4) cyc();
      check("post_rst_idle", 32'(state0), 32'd0);
      check("post_rst_count", 32'(count0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
